// File: rtl/counter_sched.sv
// Programmable interval timer sequencer around an 8-bit count register: start/stop/pause,
// terminal-count tick, one-shot done. Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_sched #(
    parameter int W     = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [W-1:0]     period,
    input  logic             mode,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRE_W-1:0] pre_div,
`endif
    output logic [W-1:0]     y,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   per_q, per_d;
    logic           mode_q, mode_d;
    logic           tick_q, tick_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           accept_s;
    logic           ce_s;

    assign accept_s = (state_q == ST_IDLE) && start && !stop && (period != {W{1'b0}});

`ifdef COUNTER_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             adv_s;

    assign adv_s = ((state_q == ST_RUN) || (state_q == ST_HOLD)) && !stop && !pause;
    assign ce_s  = (pre_cnt_q == pre_div);

    // Prescaler: cleared on accepted start or stop, frozen while paused or idle
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (accept_s || stop) begin
            pre_cnt_d = {PRE_W{1'b0}};
        end else if (adv_s) begin
            if (ce_s) begin
                pre_cnt_d = {PRE_W{1'b0}};
            end else begin
                pre_cnt_d = pre_cnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pre_cnt_q <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`else
    assign ce_s = 1'b1;
`endif

    // Next-state and next-output logic; stop beats pause beats start/count
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        per_d   = per_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    per_d   = period;
                    mode_d  = mode;
                    y_d     = {W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // The resume edge out of HOLD counts too, so a pause delays the tick by exactly its length
            ST_RUN, ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    y_d     = {W{1'b0}};
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                    if (ce_s) begin
                        if (y_q == per_q) begin
                            tick_d = 1'b1;
                            y_d    = {W{1'b0}};
                            if (mode_q) begin
                                state_d = ST_RUN;
                            end else begin
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end
                        end else begin
                            y_d = y_q + {{(W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        y_d = y_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                y_d     = {W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                y_d     = {W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

    // State, count, latched configuration and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            y_q     <= {W{1'b0}};
            per_q   <= {W{1'b0}};
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign y    = y_q;
    assign tick = tick_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed vector table, async reset sequence,
// randomized stimulus against a behavioural model (prescale path when COUNTER_PRESCALE_EN is set).
module tb_counter_sched;
    localparam int W     = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             res;
    logic             start, stop, pause, mode;
    logic [W-1:0]     period;
    logic [PRE_W-1:0] pre_div;
    logic [W-1:0]     y;
    logic             tick, done, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_y, m_per, m_pre;
    bit m_mode, m_busy, m_indone, m_tick, m_done;

    typedef struct {
        bit st, sp, pa;
        int per;
        bit md;
        int ey;
        bit et, ed, eb;
    } vec_t;
    vec_t tbl[$];

    counter_sched #(.W(W), .PRE_W(PRE_W)) dut (
        .clk(clk), .res(res), .start(start), .stop(stop), .pause(pause),
        .period(period), .mode(mode),
`ifdef COUNTER_PRESCALE_EN
        .pre_div(pre_div),
`endif
        .y(y), .tick(tick), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit st, bit sp, bit pa, int per, bit md, int ey, bit et, bit ed, bit eb);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.per = per; v.md = md;
        v.ey = ey; v.et = et; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic model_reset();
        m_y = 0; m_per = 0; m_pre = 0;
        m_mode = 1'b0; m_busy = 1'b0; m_indone = 1'b0; m_tick = 1'b0; m_done = 1'b0;
    endtask

    // One clock of the timer rules: a busy timer advances its count every (div+1) unpaused cycles
    task automatic model_step();
        int div;
`ifdef COUNTER_PRESCALE_EN
        div = int'(pre_div);
`else
        div = 0;
`endif
        m_tick = 1'b0;
        m_done = 1'b0;
        if (m_indone) begin
            m_indone = 1'b0;
        end else if (!m_busy) begin
            if (start && !stop && period != 0) begin
                m_per = int'(period); m_mode = mode; m_y = 0; m_pre = 0; m_busy = 1'b1;
            end
        end else if (stop) begin
            m_busy = 1'b0; m_y = 0; m_pre = 0;
        end else if (!pause) begin
            if (m_pre < div) begin
                m_pre = m_pre + 1;
            end else begin
                m_pre = 0;
                if (m_y == m_per) begin
                    m_tick = 1'b1;
                    m_y    = 0;
                    if (!m_mode) begin
                        m_done = 1'b1; m_busy = 1'b0; m_indone = 1'b1;
                    end
                end else begin
                    m_y = m_y + 1;
                end
            end
        end
    endtask

    task automatic check(string name, int ey, bit et, bit ed, bit eb);
        n_cmp++;
        if (y !== ey[W-1:0] || tick !== et || done !== ed || busy !== eb) begin
            n_err++;
            $display("FAIL %s: got y=%0d tick=%0b done=%0b busy=%0b, expected y=%0d tick=%0b done=%0b busy=%0b",
                     name, y, tick, done, busy, ey, et, ed, eb);
        end
    endtask

    // Called at a negedge with inputs already applied
    task automatic cyc(string name);
        @(posedge clk);
        model_step();
        #2;
        check(name, m_y, m_tick, m_done, m_busy);
        @(negedge clk);
    endtask

    task automatic drive(bit st, bit sp, bit pa, int per, bit md);
        start = st; stop = sp; pause = pa; period = per[W-1:0]; mode = md;
    endtask

    initial begin
        res = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        pre_div = '0;
        model_reset();
        #12;
        check("reset_state", 0, 1'b0, 1'b0, 1'b0);
        #5;
        res = 1'b1;
        @(negedge clk);

        // Auto-reload P=3, stop, one-shot P=5 with DONE-ignored start, zero period, stop+start, pause
        tbl.push_back(mk(1,0,0,3,1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 2,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 3,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,1));
        tbl.push_back(mk(1,0,0,6,0, 1,0,0,1));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,5,0, 0,0,0,1));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,0,0,0, k,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(1,0,0,2,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,9,1, 0,0,0,1));
        for (int k = 1; k <= 4; k++) tbl.push_back(mk(0,0,0,0,0, k,0,0,1));
        tbl.push_back(mk(1,1,0,9,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,7,1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 2,0,0,1));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,1,0,0, 2,0,0,1));
        for (int k = 3; k <= 7; k++) tbl.push_back(mk(0,0,0,0,0, k,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0,1));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0, 0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].per, tbl[i].md);
            cyc($sformatf("model_vec%0d", i));
            check($sformatf("vec%0d", i), tbl[i].ey, tbl[i].et, tbl[i].ed, tbl[i].eb);
        end

        // Asynchronous reset in the middle of a run at y=7
        drive(1'b1, 1'b0, 1'b0, 9, 1'b1);
        cyc("rst_seq_start");
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 7; k++) cyc("rst_seq_run");
        check("rst_seq_y7", 7, 1'b0, 1'b0, 1'b1);
        #2;
        res = 1'b0;
        #1;
        check("async_rst", 0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        res = 1'b1;
        cyc("post_rst_idle");
        check("post_rst_const", 0, 1'b0, 1'b0, 1'b0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaled auto-reload: pre_div=2, P=1 gives y every 3 cycles, tick every 6
        pre_div = 4'd2;
        drive(1'b1, 1'b0, 1'b0, 1, 1'b1);
        cyc("pre_start");
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc("pre_run");
            check($sformatf("pre_tick%0d", k), (k % 6 >= 3) ? 1 : 0, (k % 6 == 0), 1'b0, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc("pre_stop");
        pre_div = PRE_W'($urandom_range(3));
`endif

        for (int k = 0; k < 3000; k++) begin
            start  = ($urandom_range(7) == 0);
            stop   = ($urandom_range(40) == 0);
            pause  = ($urandom_range(5) == 0);
            period = ($urandom_range(15) == 0) ? W'($urandom_range(255)) : W'($urandom_range(12));
            mode   = 1'($urandom_range(1));
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
